// File: rtl/ikbd_sci_rx_fifo.sv
// 8N1 serial receiver for the HD63701 SCI TX line, feeding a small byte FIFO
// read by the ACIA side. Sticky framing-error and overrun flags.
module ikbd_sci_rx_fifo #(
  parameter int DIVISOR = 256,
  parameter int DEPTH   = 4
) (
  input  logic       CLKx2,
  input  logic       RST_N,
  input  logic       RXD,
  input  logic       EN,
  output logic [7:0] DOUT,
  output logic       DVALID,
  input  logic       DREAD,
  output logic       FE,
  output logic       OVR,
  input  logic       ERR_CLR,
  output logic       BUSY
);

  localparam int CW = $clog2(DIVISOR);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2 - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAITHI} state_t;

  state_t          r_state, w_nxt_state;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic [2:0]      r_idx, w_nxt_idx;
  logic [7:0]      r_shift, w_nxt_shift;
  logic            r_sync1, r_rxs, r_rxs_d;
  logic            w_push, w_fe_set;

  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;
  logic [7:0]      r_dout, w_nxt_dout;
  logic            r_fe, r_ovr;
  logic            w_empty, w_full, w_pop, w_push_ok, w_ovr_set;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge CLKx2 or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  always_ff @(posedge CLKx2 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_idx   <= w_nxt_idx;
      r_shift <= w_nxt_shift;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx;
    w_nxt_shift = r_shift;
    w_push      = 1'b0;
    w_fe_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rxs_d && !r_rxs) begin
          w_nxt_state = S_START;
          w_nxt_cnt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_nxt_cnt = '0;
          w_nxt_idx = '0;
          w_nxt_state = r_rxs ? S_IDLE : S_DATA;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_MAX) begin
          w_nxt_cnt   = '0;
          w_nxt_shift = {r_rxs, r_shift[7:1]};
          if (r_idx == 3'd7) w_nxt_state = S_STOP;
          else               w_nxt_idx   = r_idx + 3'd1;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_MAX) begin
          w_nxt_cnt = '0;
          if (r_rxs) begin
            w_push      = 1'b1;
            w_nxt_state = S_IDLE;
          end else begin
            w_fe_set    = 1'b1;
            w_nxt_state = S_WAITHI;
          end
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_WAITHI: begin
        if (r_rxs) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // Disabling drops any frame in progress, including one finishing this edge.
    if (!EN) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
      w_push      = 1'b0;
      w_fe_set    = 1'b0;
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  assign w_pop     = DREAD && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  // Head register tracks the entry that will be at the read pointer after this edge.
  always_comb begin
    w_nxt_dout = r_dout;
    if (w_empty) begin
      if (w_push_ok) w_nxt_dout = r_shift;
    end else if (w_pop) begin
      if (r_count == (PW + 1)'(1)) begin
        if (w_push_ok) w_nxt_dout = r_shift;
      end else begin
        w_nxt_dout = r_mem[r_rd_ptr + PW'(1)];
      end
    end
  end

  always_ff @(posedge CLKx2) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge CLKx2 or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_fe     <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_dout <= w_nxt_dout;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_fe_set)     r_fe <= 1'b1;
      else if (ERR_CLR) r_fe <= 1'b0;
      if (w_ovr_set)    r_ovr <= 1'b1;
      else if (ERR_CLR) r_ovr <= 1'b0;
    end
  end

  assign DOUT   = r_dout;
  assign DVALID = !w_empty;
  assign FE     = r_fe;
  assign OVR    = r_ovr;
  assign BUSY   = (r_state != S_IDLE);

endmodule

// File: tb/tb_ikbd_sci_rx_fifo.sv
// Directed bench for ikbd_sci_rx_fifo at DIVISOR=16, DEPTH=4: a vector table of
// whole frames plus hand sequences for glitch, break, overrun, enable and reset.
module tb_ikbd_sci_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       en = 1'b1;
  logic       dread = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       dvalid, fe, ovr, busy;

  int n_vec = 0;
  int n_err = 0;

  ikbd_sci_rx_fifo #(.DIVISOR(16), .DEPTH(4)) dut (
    .CLKx2(clk), .RST_N(rst_n), .RXD(rxd), .EN(en),
    .DOUT(dout), .DVALID(dvalid), .DREAD(dread),
    .FE(fe), .OVR(ovr), .ERR_CLR(err_clr), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop_after;
    logic [7:0] exp_dout;
    logic       exp_dvalid;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop;
    dread = 1'b1;
    cyc(1);
    dread = 1'b0;
  endtask

  task automatic clear_err;
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  // Drives start/data/stop at 16 clocks per bit for ncyc clocks; RXD is left at
  // the last driven level. Mode 1 pulses DREAD and mode 2 pulses ERR_CLR onto
  // the stop-sample edge (clock 155); mode 3 checks DVALID rises exactly there.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int mode, input int ncyc);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    rxd = bits[0];
    for (int c = 1; c <= ncyc; c++) begin
      cyc(1);
      if (c == 154) begin
        if (mode == 1) dread = 1'b1;
        if (mode == 2) err_clr = 1'b1;
        if (mode == 3) check("dvalid_before_stop_edge", dvalid, 1'b0);
      end
      if (c == 155) begin
        dread = 1'b0;
        err_clr = 1'b0;
        if (mode == 3) check("dvalid_after_stop_edge", dvalid, 1'b1);
      end
      if (c < 160) rxd = bits[c / 16];
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};

    cyc(3);
    check("rst_dout", dout, 8'h00);
    check("rst_dvalid", dvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    cyc(4);
    check("post_rst_fe", fe, 1'b0);
    check("post_rst_ovr", ovr, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // Whole-frame vector table; the first frame also checks push latency.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, (i == 0) ? 3 : 0, 160);
      check("vec_dout", dout, vecs[i].exp_dout);
      check("vec_dvalid", dvalid, vecs[i].exp_dvalid);
      check("vec_fe", fe, vecs[i].exp_fe);
      check("vec_ovr", ovr, vecs[i].exp_ovr);
      if (vecs[i].pop_after) begin
        pop();
        check("vec_dvalid_after_pop", dvalid, 1'b0);
      end
      rxd = 1'b1;
      cyc(20);
      if (vecs[i].exp_fe) begin
        clear_err();
        check("vec_fe_cleared", fe, 1'b0);
      end
    end

    // Short low glitch: false start, no byte, no error.
    rxd = 1'b0;
    cyc(4);
    check("glitch_busy", busy, 1'b1);
    cyc(1);
    rxd = 1'b1;
    cyc(30);
    check("glitch_idle", busy, 1'b0);
    check("glitch_dvalid", dvalid, 1'b0);
    check("glitch_fe", fe, 1'b0);

    // Break: bad stop bit then line held low for 40 bit times.
    send_frame(8'h3C, 1'b0, 0, 160);
    cyc(640);
    check("break_fe", fe, 1'b1);
    check("break_busy", busy, 1'b1);
    check("break_dvalid", dvalid, 1'b0);
    rxd = 1'b1;
    cyc(10);
    check("break_release_busy", busy, 1'b0);
    check("break_fe_sticky", fe, 1'b1);
    clear_err();
    check("break_fe_clr", fe, 1'b0);

    // Framing error coinciding with ERR_CLR: the set wins.
    send_frame(8'h11, 1'b0, 2, 160);
    check("fe_set_wins", fe, 1'b1);
    rxd = 1'b1;
    cyc(10);
    clear_err();

    // Overrun: five bytes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0, 160);
      cyc(4);
    end
    check("ovr_set", ovr, 1'b1);
    check("ovr_dvalid", dvalid, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check("ovr_readback", dout, 8'(k));
      pop();
    end
    check("ovr_empty", dvalid, 1'b0);
    check("ovr_dout_hold", dout, 8'h04);
    pop();
    check("ovr_pop_empty_ignored", dvalid, 1'b0);
    clear_err();
    check("ovr_clr", ovr, 1'b0);

    // Full FIFO with a pop on the same edge as the fifth push.
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, 0, 160);
      cyc(4);
    end
    send_frame(8'h05, 1'b1, 1, 160);
    cyc(4);
    check("simul_ovr", ovr, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      check("simul_dvalid", dvalid, 1'b1);
      check("simul_readback", dout, 8'(k));
      pop();
    end
    check("simul_empty", dvalid, 1'b0);

    // Disabled receiver ignores a whole frame.
    en = 1'b0;
    send_frame(8'h77, 1'b1, 0, 160);
    cyc(4);
    check("en_off_dvalid", dvalid, 1'b0);
    check("en_off_busy", busy, 1'b0);
    en = 1'b1;
    cyc(4);

    // Dropping EN mid-frame aborts it but keeps FIFO contents readable.
    send_frame(8'h42, 1'b1, 0, 160);
    cyc(4);
    send_frame(8'hC3, 1'b1, 0, 40);
    check("en_mid_busy", busy, 1'b1);
    en = 1'b0;
    cyc(1);
    check("en_mid_abort", busy, 1'b0);
    rxd = 1'b1;
    cyc(20);
    en = 1'b1;
    cyc(200);
    check("en_retain_dvalid", dvalid, 1'b1);
    check("en_retain_dout", dout, 8'h42);
    pop();
    check("en_retain_pop", dvalid, 1'b0);
    check("en_flags_fe", fe, 1'b0);

    // Reset during bit 4 of 0x55, then a clean 0x99.
    send_frame(8'h55, 1'b1, 0, 72);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_dout", dout, 8'h00);
    rxd = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    send_frame(8'h99, 1'b1, 0, 160);
    cyc(4);
    check("midrst_new_dout", dout, 8'h99);
    check("midrst_new_dvalid", dvalid, 1'b1);
    check("midrst_fe", fe, 1'b0);
    check("midrst_ovr", ovr, 1'b0);
    pop();
    check("midrst_only_one", dvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
